// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid + sticky side-field, steered by the
// ctrl stall vector and flush, with saturating bubble/hold/flush profiling counters.
module pipe_stage_reg #(
    parameter int                DATA_W   = 128,
    parameter int                STICKY_W = 1,
    parameter int                STALL_W  = 6,
    parameter int                STAGE    = 2,
    parameter logic [DATA_W-1:0] NOP_VAL  = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                in_valid_i,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [STICKY_W-1:0] in_sticky_i,
    input  logic                cnt_clr_i,
    output logic                out_valid_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [STICKY_W-1:0] out_sticky_o,
    output logic [CNT_W-1:0]    bubble_cnt_o,
    output logic [CNT_W-1:0]    hold_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must satisfy 0 <= STAGE <= STALL_W-2");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic w_up;
    logic w_dn;
    logic w_bubble;
    logic w_hold;

    assign w_up     = stall[STAGE];
    assign w_dn     = stall[STAGE+1];
    assign w_bubble = !flush && w_up && !w_dn;
    assign w_hold   = !flush && w_up && w_dn;

    logic                r_valid_p1;
    logic [DATA_W-1:0]   r_data_p1;
    logic [STICKY_W-1:0] r_sticky_p1;
    logic [CNT_W-1:0]    r_bubble_cnt;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    // stage boundary: upstream slot -> registered slot (one action per cycle)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid_p1  <= 1'b0;
            r_data_p1   <= NOP_VAL;
            r_sticky_p1 <= '0;
        end else if (w_bubble) begin
            // sticky survives bubbles so a delay-slot flag is not lost during stalls
            r_valid_p1 <= 1'b0;
            r_data_p1  <= NOP_VAL;
        end else if (!w_up) begin
            r_valid_p1  <= in_valid_i;
            r_data_p1   <= in_data_i;
            r_sticky_p1 <= in_sticky_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr_i) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (flush)    r_flush_cnt  <= sat_inc(r_flush_cnt);
            if (w_bubble) r_bubble_cnt <= sat_inc(r_bubble_cnt);
            if (w_hold)   r_hold_cnt   <= sat_inc(r_hold_cnt);
        end
    end

    assign out_valid_o  = r_valid_p1;
    assign out_data_o   = r_data_p1;
    assign out_sticky_o = r_sticky_p1;
    assign bubble_cnt_o = r_bubble_cnt;
    assign hold_cnt_o   = r_hold_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (STAGE=2, CNT_W=4 so saturation is reachable quickly).
module tb_pipe_stage_reg;

    localparam int DW = 128;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [0:0]    in_sticky;
    logic          cnt_clr;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [0:0]    out_sticky;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] PAT_3C = {16{8'h3C}};
    localparam logic [DW-1:0] PAT_77 = {16{8'h77}};

    pipe_stage_reg #(
        .DATA_W(DW), .STICKY_W(1), .STALL_W(6), .STAGE(2), .NOP_VAL('0), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_sticky_i(in_sticky),
        .cnt_clr_i(cnt_clr),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_sticky_o(out_sticky),
        .bubble_cnt_o(bubble_cnt), .hold_cnt_o(hold_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [DW-1:0] d, input logic s);
        check_eq({tag, ".valid"}, DW'(out_valid), DW'(v));
        check_eq({tag, ".data"}, out_data, d);
        check_eq({tag, ".sticky"}, DW'(out_sticky), DW'(s));
    endtask

    task automatic check_cnt(input string tag, input int b, input int h, input int f);
        check_eq({tag, ".bubble"}, DW'(bubble_cnt), DW'(b));
        check_eq({tag, ".hold"}, DW'(hold_cnt), DW'(h));
        check_eq({tag, ".flush"}, DW'(flush_cnt), DW'(f));
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b1;
        in_data = PAT_77; in_sticky = 1'b1; cnt_clr = 1'b0;
        tick(2);
        check_slot("reset", 1'b0, '0, 1'b0);
        check_cnt("reset", 0, 0, 0);

        // advance
        rst = 1'b0; in_valid = 1'b1; in_data = PAT_A5; in_sticky = 1'b1;
        tick(1);
        check_slot("adv", 1'b1, PAT_A5, 1'b1);

        // bubble x3: NOP loaded, sticky held
        stall = 6'b000100; in_data = PAT_3C; in_sticky = 1'b0;
        tick(3);
        check_slot("bubble", 1'b0, '0, 1'b1);
        check_cnt("bubble", 3, 0, 0);

        // load a fresh value, then hold x4 with changing inputs
        stall = 6'b000000; in_valid = 1'b1; in_data = PAT_3C; in_sticky = 1'b0;
        tick(1);
        check_slot("adv2", 1'b1, PAT_3C, 1'b0);
        stall = 6'b001100;
        for (int i = 0; i < 4; i++) begin
            in_data = {16{i[7:0]}}; in_valid = i[0]; in_sticky = ~i[0];
            tick(1);
        end
        check_slot("hold", 1'b1, PAT_3C, 1'b0);
        check_cnt("hold", 3, 4, 0);

        // up=0, dn=1 still advances; invalid payload registered verbatim
        stall = 6'b001000; in_valid = 1'b0; in_data = PAT_77; in_sticky = 1'b1;
        tick(1);
        check_slot("adv_dn", 1'b0, PAT_77, 1'b1);
        check_cnt("adv_dn", 3, 4, 0);

        // flush during hold pattern, then during bubble pattern
        flush = 1'b1; stall = 6'b001100;
        tick(1);
        check_slot("flush_h", 1'b0, '0, 1'b0);
        check_cnt("flush_h", 3, 4, 1);
        stall = 6'b000100;
        tick(1);
        check_cnt("flush_b", 3, 4, 2);

        // saturation: 20 more bubbles on top of 3
        flush = 1'b0; stall = 6'b000000; in_valid = 1'b1; in_data = PAT_A5; in_sticky = 1'b1;
        tick(1);
        stall = 6'b000100;
        tick(20);
        check_cnt("sat", 15, 4, 2);
        check_slot("sat", 1'b0, '0, 1'b1);

        // clear during a bubble overrides the increment, leaves slot alone
        cnt_clr = 1'b1;
        tick(1);
        check_cnt("clr", 0, 0, 0);
        check_slot("clr", 1'b0, '0, 1'b1);
        cnt_clr = 1'b0;
        tick(1);
        check_cnt("post_clr", 1, 0, 0);

        // reset wins over flush and stall
        stall = 6'b001100; tick(2);
        rst = 1'b1; flush = 1'b1;
        tick(1);
        check_slot("rst_mid", 1'b0, '0, 1'b0);
        check_cnt("rst_mid", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
